// File: rtl/mips_defines.sv
// rtl/mips_defines.sv - opcodes, access sizes and MEM-stage FSM states shared by the MEM stage.
package mips_defines;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CANCEL,
    ST_DONE
  } mem_state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] access_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
      default:              return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects the addressed byte/half of returned load data and extends it.
module load_extend
  import mips_defines::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [5:0]  opcode,
  output logic [31:0] result
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  always_comb begin
    byte_sh = rdata >> {addr_lo, 3'b000};
    half_sh = rdata >> {addr_lo[1], 4'b0000};
    case (opcode)
      OP_LB:   result = {{24{byte_sh[7]}}, byte_sh[7:0]};
      OP_LBU:  result = {24'h0, byte_sh[7:0]};
      OP_LH:   result = {{16{half_sh[15]}}, half_sh[15:0]};
      OP_LHU:  result = {16'h0, half_sh[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: one sram-like bus access per load/store, address-error
// detection, pipeline stall request and write-back value selection.
module mem_access_stage
  import mips_defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_validM,
  input  logic [31:0] instrM,
  input  logic [31:0] alu_outM,
  input  logic [31:0] rt_valueM,
  input  logic        flush_exceptM,
  input  logic        stallM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] resultM,
  output logic        stall_req,
  output logic        adelM,
  output logic        adesM,
  output logic [31:0] badvaddrM
);

  mem_state_t  state, state_n;
  logic [31:0] rdata_q;
  logic [31:0] load_value;

  logic [5:0]  op;
  logic        ld, st, misalign, issue;
  logic [1:0]  size;
  logic [3:0]  strb;
  logic [31:0] lanes;
  logic        req_c, stall_c;

  assign op       = instrM[31:26];
  assign ld       = is_load(op);
  assign st       = is_store(op);
  assign size     = access_size(op);
  assign misalign = ((size == SIZE_HALF) && alu_outM[0]) ||
                    ((size == SIZE_WORD) && (alu_outM[1:0] != 2'b00));
  assign issue    = inst_validM && (ld || st) && !misalign && !flush_exceptM;

  always_comb begin
    strb  = 4'b1111;
    lanes = rt_valueM;
    case (size)
      SIZE_BYTE: begin
        strb  = 4'b0001 << alu_outM[1:0];
        lanes = {4{rt_valueM[7:0]}};
      end
      SIZE_HALF: begin
        strb  = alu_outM[1] ? 4'b1100 : 4'b0011;
        lanes = {2{rt_valueM[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rdata_q <= 32'h0;
    end else begin
      state <= state_n;
      if (state == ST_WAIT && data_data_ok)
        rdata_q <= data_rdata;
    end
  end

  // A flush that coincides with acceptance still leaves a transfer in flight, so drain it.
  always_comb begin
    state_n = state;
    req_c   = 1'b0;
    stall_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (issue) begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          state_n = data_addr_ok ? ST_WAIT : ST_REQ;
        end
      end
      ST_REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (data_addr_ok)
          state_n = flush_exceptM ? ST_CANCEL : ST_WAIT;
        else if (flush_exceptM)
          state_n = ST_IDLE;
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        if (data_data_ok)
          state_n = ST_DONE;
        else if (flush_exceptM)
          state_n = ST_CANCEL;
      end
      ST_CANCEL: begin
        stall_c = 1'b1;
        if (data_data_ok)
          state_n = ST_IDLE;
      end
      ST_DONE: begin
        if (flush_exceptM || !stallM)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  load_extend u_load_extend (
    .rdata   (rdata_q),
    .addr_lo (alu_outM[1:0]),
    .opcode  (op),
    .result  (load_value)
  );

  // Outputs are forced low while reset is held so the bus sees nothing during an async reset.
  always_comb begin
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = 32'h0;
    data_wstrb = 4'h0;
    data_wdata = 32'h0;
    resultM    = 32'h0;
    stall_req  = 1'b0;
    adelM      = 1'b0;
    adesM      = 1'b0;
    badvaddrM  = 32'h0;
    if (!rst) begin
      data_req  = req_c;
      stall_req = stall_c;
      if (req_c) begin
        data_wr    = st;
        data_size  = size;
        data_addr  = alu_outM;
        data_wstrb = st ? strb : 4'h0;
        data_wdata = st ? lanes : 32'h0;
      end
      resultM = (state == ST_DONE && ld) ? load_value : alu_outM;
      adelM   = (state == ST_IDLE) && inst_validM && ld && misalign;
      adesM   = (state == ST_IDLE) && inst_validM && st && misalign;
      if (adelM || adesM)
        badvaddrM = alu_outM;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed MEM-stage bench with an expected-result scoreboard.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_validM;
  logic [31:0] instrM;
  logic [31:0] alu_outM;
  logic [31:0] rt_valueM;
  logic        flush_exceptM;
  logic        stallM;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] resultM;
  logic        stall_req;
  logic        adelM;
  logic        adesM;
  logic [31:0] badvaddrM;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int req_cycles;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk           (clk),
    .rst           (rst),
    .inst_validM   (inst_validM),
    .instrM        (instrM),
    .alu_outM      (alu_outM),
    .rt_valueM     (rt_valueM),
    .flush_exceptM (flush_exceptM),
    .stallM        (stallM),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_size     (data_size),
    .data_addr     (data_addr),
    .data_wstrb    (data_wstrb),
    .data_wdata    (data_wdata),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .data_rdata    (data_rdata),
    .resultM       (resultM),
    .stall_req     (stall_req),
    .adelM         (adelM),
    .adesM         (adesM),
    .badvaddrM     (badvaddrM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed 0x%08h expected <scoreboard empty>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      chk(tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a new instruction that is accepted in its first cycle.
  task automatic start_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] exp_res);
    inst_validM  = 1'b1;
    instrM       = {op, 26'h0};
    alu_outM     = addr;
    rt_valueM    = rt;
    data_addr_ok = 1'b1;
    exp_q.push_back(exp_res);
    #1;
  endtask

  // Returns data one cycle after acceptance, then checks the DONE cycle against the scoreboard.
  task automatic finish_op(input string tag, input logic [31:0] rdata);
    step();
    inst_validM  = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = rdata;
    #1;
    chk({tag, "_stall_wait"}, {31'h0, stall_req}, 32'h1);
    step();
    data_data_ok = 1'b0;
    #1;
    chk({tag, "_stall_done"}, {31'h0, stall_req}, 32'h0);
    pop_chk({tag, "_result"}, resultM);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    inst_validM = 1'b0;
    instrM = 32'h0;
    alu_outM = 32'h55;
    rt_valueM = 32'h0;
    flush_exceptM = 1'b0;
    stallM = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata = 32'h0;
    step();
    step();
    chk("reset_result", resultM, 32'h0);
    chk("reset_stall", {31'h0, stall_req}, 32'h0);
    rst = 1'b0;
    #1;
    chk("idle_result_passthru", resultM, 32'h55);

    // 1: LW with late addr_ok and slow data_ok
    inst_validM = 1'b1;
    instrM = {6'h23, 26'h0};
    alu_outM = 32'h1000;
    exp_q.push_back(32'hDEADBEEF);
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      data_addr_ok = (i == 2);
      #1;
      req_cycles += int'(data_req);
      chk("t1_stall_req_phase", {31'h0, stall_req}, 32'h1);
      step();
      inst_validM = 1'b0;
    end
    data_addr_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      req_cycles += int'(data_req);
      chk("t1_stall_wait", {31'h0, stall_req}, 32'h1);
      step();
    end
    data_data_ok = 1'b1;
    data_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_stall_dataok", {31'h0, stall_req}, 32'h1);
    step();
    data_data_ok = 1'b0;
    #1;
    chk("t1_stall_done", {31'h0, stall_req}, 32'h0);
    pop_chk("t1_result", resultM);
    chk("t1_req_cycles", req_cycles, 32'd3);
    step();

    // 2: sub-word loads
    start_op(6'h20, 32'h1003, 32'h0, 32'hFFFFFF80);
    chk("t2_lb_size", {30'h0, data_size}, 32'h0);
    finish_op("t2_lb", 32'h80123456);
    start_op(6'h24, 32'h1003, 32'h0, 32'h00000080);
    finish_op("t2_lbu", 32'h80123456);
    start_op(6'h25, 32'h1002, 32'h0, 32'h00008012);
    chk("t2_lhu_strb", {28'h0, data_wstrb}, 32'h0);
    finish_op("t2_lhu", 32'h80123456);

    // 3: SB lane replication and byte enable
    start_op(6'h28, 32'h2002, 32'h12345678, 32'h2002);
    chk("t3_req", {31'h0, data_req}, 32'h1);
    chk("t3_wdata", data_wdata, 32'h78787878);
    chk("t3_wstrb", {28'h0, data_wstrb}, 32'h4);
    chk("t3_size", {30'h0, data_size}, 32'h0);
    chk("t3_wr", {31'h0, data_wr}, 32'h1);
    chk("t3_addr", data_addr, 32'h2002);
    finish_op("t3_sb", 32'h0);

    // 4: misaligned accesses
    inst_validM = 1'b1;
    instrM = {6'h23, 26'h0};
    alu_outM = 32'h1002;
    #1;
    chk("t4_adel", {31'h0, adelM}, 32'h1);
    chk("t4_badvaddr", badvaddrM, 32'h1002);
    chk("t4_no_req", {31'h0, data_req}, 32'h0);
    chk("t4_no_stall", {31'h0, stall_req}, 32'h0);
    step();
    instrM = {6'h29, 26'h0};
    alu_outM = 32'h2001;
    #1;
    chk("t4_ades", {31'h0, adesM}, 32'h1);
    chk("t4_adel_clear", {31'h0, adelM}, 32'h0);
    chk("t4_sh_no_req", {31'h0, data_req}, 32'h0);
    step();
    inst_validM = 1'b0;

    // 5: flush during WAIT drains into CANCEL
    start_op(6'h23, 32'h3000, 32'h0, 32'h0);
    void'(exp_q.pop_back());
    step();
    inst_validM = 1'b0;
    data_addr_ok = 1'b0;
    flush_exceptM = 1'b1;
    #1;
    step();
    flush_exceptM = 1'b0;
    #1;
    chk("t5_cancel_stall", {31'h0, stall_req}, 32'h1);
    chk("t5_cancel_no_req", {31'h0, data_req}, 32'h0);
    step();
    data_data_ok = 1'b1;
    data_rdata = 32'h00000BAD;
    #1;
    chk("t5_cancel_stall_dataok", {31'h0, stall_req}, 32'h1);
    step();
    data_data_ok = 1'b0;
    #1;
    chk("t5_after_stall", {31'h0, stall_req}, 32'h0);
    chk("t5_data_discarded", resultM, 32'h3000);
    start_op(6'h25, 32'h1002, 32'h0, 32'h0000CAFE);
    chk("t5_next_req", {31'h0, data_req}, 32'h1);
    finish_op("t5_next", 32'hCAFE1234);

    // 6: async reset in WAIT, then DONE held by stallM
    start_op(6'h23, 32'h4000, 32'h0, 32'h0);
    void'(exp_q.pop_back());
    step();
    inst_validM = 1'b0;
    data_addr_ok = 1'b0;
    #1;
    chk("t6_wait_stall", {31'h0, stall_req}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_stall", {31'h0, stall_req}, 32'h0);
    chk("t6_rst_result", resultM, 32'h0);
    chk("t6_rst_req", {31'h0, data_req}, 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("t6_idle_stall", {31'h0, stall_req}, 32'h0);
    chk("t6_idle_result", resultM, 32'h4000);
    start_op(6'h23, 32'h1000, 32'h0, 32'h11223344);
    step();
    inst_validM = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata = 32'h11223344;
    stallM = 1'b1;
    step();
    data_data_ok = 1'b0;
    data_rdata = 32'hFFFFFFFF;
    #1;
    pop_chk("t6_done_result", resultM);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_hold_result", resultM, 32'h11223344);
      chk("t6_hold_no_req", {31'h0, data_req}, 32'h0);
      chk("t6_hold_no_stall", {31'h0, stall_req}, 32'h0);
    end
    stallM = 1'b0;
    step();
    #1;
    chk("t6_released_result", resultM, 32'h1000);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
